// File: rtl/ram_arb_pkg.sv
// Shared constants, index-width helper and arbiter state encoding for the RAM port arbiters.
package ram_arb_pkg;

  localparam int CReqCntMax = 8;

  typedef enum logic [0:0] {
    ArbFree   = 1'b0,
    ArbLocked = 1'b1
  } arb_state_e;

  // ceil(log2(n)), never below 1 so a two-entry index still has a bit.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ram_port_arb_if.sv
// Requester-side and RAM-side bus of ram_port_arb; master = clients plus RAM, slave = arbiter.
interface ram_port_arb_if #(
  parameter int CAddrLen = 11,
  parameter int CDataLen = 8,
  parameter int CReqCnt  = 3
);

  logic [CReqCnt*CAddrLen-1:0] AReqAddr;
  logic [CReqCnt*CDataLen-1:0] AReqMosi;
  logic [CReqCnt-1:0]          AReqWrEn;
  logic [CReqCnt-1:0]          AReqRdEn;
  logic [CReqCnt-1:0]          AReqLock;
  logic [CReqCnt-1:0]          AReqAck;
  logic [CDataLen-1:0]         AReqMiso;
  logic [CReqCnt-1:0]          AReqMisoVld;
  logic [CAddrLen-1:0]         ARamAddr;
  logic [CDataLen-1:0]         ARamMosi;
  logic                        ARamWrEn;
  logic                        ARamRdEn;
  logic                        ARamClkEn;
  logic [CDataLen-1:0]         ARamMiso;

  modport master (
    output AReqAddr, AReqMosi, AReqWrEn, AReqRdEn, AReqLock, ARamMiso,
    input  AReqAck, AReqMiso, AReqMisoVld,
    input  ARamAddr, ARamMosi, ARamWrEn, ARamRdEn, ARamClkEn
  );

  modport slave (
    input  AReqAddr, AReqMosi, AReqWrEn, AReqRdEn, AReqLock, ARamMiso,
    output AReqAck, AReqMiso, AReqMisoVld,
    output ARamAddr, ARamMosi, ARamWrEn, ARamRdEn, ARamClkEn
  );

endinterface

// File: rtl/ram_port_arb_rr_pick.sv
// rr_pick: combinational round-robin picker, searching upward from last+1 with wrap.
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int CReqCnt = 3,
  parameter int CIdxLen = idx_width(CReqCnt)
) (
  input  logic [CReqCnt-1:0] req_i,
  input  logic [CIdxLen-1:0] last_i,
  output logic [CReqCnt-1:0] gnt_o,
  output logic [CIdxLen-1:0] idx_o,
  output logic               vld_o
);

  // Candidates in priority order are last+1 .. last+CReqCnt modulo CReqCnt.
  always_comb begin
    logic [CIdxLen:0]   sum_s;
    logic [CIdxLen-1:0] cand_s;
    logic               hit_s;
    gnt_o  = '0;
    idx_o  = '0;
    vld_o  = 1'b0;
    sum_s  = '0;
    cand_s = '0;
    hit_s  = 1'b0;
    for (int k = 1; k <= CReqCnt; k++) begin
      sum_s  = {1'b0, last_i} + (CIdxLen+1)'(k);
      cand_s = (sum_s >= (CIdxLen+1)'(CReqCnt)) ?
               CIdxLen'(sum_s - (CIdxLen+1)'(CReqCnt)) : CIdxLen'(sum_s);
      hit_s  = req_i[cand_s] & ~vld_o;
      gnt_o[cand_s] = gnt_o[cand_s] | hit_s;
      idx_o  = hit_s ? cand_s : idx_o;
      vld_o  = vld_o | hit_s;
    end
  end

endmodule

// File: rtl/ram_port_arb.sv
// Round-robin arbiter sharing one RAM port among CReqCnt requesters with read-data return.
// Optional requester locking is built when RAM_ARB_LOCK_EN is defined.
module ram_port_arb
  import ram_arb_pkg::*;
#(
  parameter int CAddrLen = 11,
  parameter int CDataLen = 8,
  parameter int CReqCnt  = 3
) (
  input  logic          AClk,
  input  logic          AResetN,
  ram_port_arb_if.slave bus
);

  localparam int CIdxLen = idx_width(CReqCnt);

  logic [CReqCnt-1:0] pend_s;
  logic [CReqCnt-1:0] elig_s;
  logic [CReqCnt-1:0] gnt_s;
  logic [CIdxLen-1:0] gnt_idx_s;
  logic               gnt_vld_s;
  logic               gnt_wr_s;
  logic               gnt_rd_s;
  logic [CIdxLen-1:0] flast_d, flast_q;
  logic [CReqCnt-1:0] rd_pend_d, rd_pend_q;

  assign pend_s = bus.AReqWrEn | bus.AReqRdEn;

`ifdef RAM_ARB_LOCK_EN
  arb_state_e         state_d, state_q;
  logic [CIdxLen-1:0] lock_own_d, lock_own_q;

  // While locked, only the owner is eligible even when it is idle.
  always_comb begin
    elig_s = pend_s;
    if (state_q == ArbLocked) begin
      elig_s = pend_s & (CReqCnt'(1'b1) << lock_own_q);
    end else begin
      elig_s = pend_s;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_own_d = lock_own_q;
    case (state_q)
      ArbFree: begin
        if (gnt_vld_s && bus.AReqLock[gnt_idx_s]) begin
          state_d    = ArbLocked;
          lock_own_d = gnt_idx_s;
        end else begin
          state_d    = ArbFree;
        end
      end
      ArbLocked: begin
        if (!bus.AReqLock[lock_own_q]) begin
          state_d = ArbFree;
        end else begin
          state_d = ArbLocked;
        end
      end
      default: begin
        state_d = ArbFree;
      end
    endcase
  end

  always_ff @(posedge AClk) begin
    if (!AResetN) begin
      state_q    <= ArbFree;
      lock_own_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_own_q <= lock_own_d;
    end
  end
`else
  logic unused_lock_s;
  assign unused_lock_s = ^bus.AReqLock;
  assign elig_s        = pend_s;
`endif

  rr_pick #(
    .CReqCnt (CReqCnt),
    .CIdxLen (CIdxLen)
  ) u_rr_pick (
    .req_i  (elig_s),
    .last_i (flast_q),
    .gnt_o  (gnt_s),
    .idx_o  (gnt_idx_s),
    .vld_o  (gnt_vld_s)
  );

  // Write wins when both enables are set, so such a grant never issues a read.
  assign gnt_wr_s = gnt_vld_s & bus.AReqWrEn[gnt_idx_s];
  assign gnt_rd_s = gnt_vld_s & bus.AReqRdEn[gnt_idx_s] & ~bus.AReqWrEn[gnt_idx_s];

  assign bus.ARamClkEn = 1'b1;

  always_comb begin
    bus.AReqAck     = '0;
    bus.ARamAddr    = '0;
    bus.ARamMosi    = '0;
    bus.ARamWrEn    = 1'b0;
    bus.ARamRdEn    = 1'b0;
    bus.AReqMisoVld = '0;
    bus.AReqMiso    = '0;
    if (AResetN && gnt_vld_s) begin
      bus.AReqAck  = gnt_s;
      bus.ARamAddr = bus.AReqAddr[int'(gnt_idx_s)*CAddrLen +: CAddrLen];
      bus.ARamMosi = bus.AReqMosi[int'(gnt_idx_s)*CDataLen +: CDataLen];
      bus.ARamWrEn = gnt_wr_s;
      bus.ARamRdEn = gnt_rd_s;
    end else begin
      bus.AReqAck  = '0;
      bus.ARamWrEn = 1'b0;
      bus.ARamRdEn = 1'b0;
    end
    // Gating on AResetN drops a read return that collides with reset.
    if (AResetN && (|rd_pend_q)) begin
      bus.AReqMisoVld = rd_pend_q;
      bus.AReqMiso    = bus.ARamMiso;
    end else begin
      bus.AReqMisoVld = '0;
      bus.AReqMiso    = '0;
    end
  end

  always_comb begin
    flast_d   = flast_q;
    rd_pend_d = '0;
    if (gnt_vld_s) begin
      flast_d   = gnt_idx_s;
      rd_pend_d = gnt_rd_s ? gnt_s : '0;
    end else begin
      flast_d   = flast_q;
      rd_pend_d = '0;
    end
  end

  // Reset places the last winner at the top index so requester 0 is searched first.
  always_ff @(posedge AClk) begin
    if (!AResetN) begin
      flast_q   <= CIdxLen'(CReqCnt-1);
      rd_pend_q <= '0;
    end else begin
      flast_q   <= flast_d;
      rd_pend_q <= rd_pend_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arb.sv
// Directed self-checking bench for ram_port_arb with a behavioural one-cycle-latency RAM.
module tb_ram_port_arb;

  localparam int CAddrLen = 11;
  localparam int CDataLen = 8;
  localparam int CReqCnt  = 3;

`ifdef RAM_ARB_LOCK_EN
  localparam int ExpAck0Cyc = 6;
  localparam int ExpReq2Gnt = 4;
`else
  localparam int ExpAck0Cyc = 2;
  localparam int ExpReq2Gnt = 3;
`endif

  logic AClk = 1'b0;
  logic AResetN;
  logic preload;
  int   compared   = 0;
  int   mismatched = 0;
  int   rnd [0:2];
  int   ack0_cyc;
  int   n2;

  logic [CDataLen-1:0] mem [0:(1<<CAddrLen)-1];

  ram_port_arb_if #(.CAddrLen(CAddrLen), .CDataLen(CDataLen), .CReqCnt(CReqCnt)) bus ();

  ram_port_arb #(.CAddrLen(CAddrLen), .CDataLen(CDataLen), .CReqCnt(CReqCnt)) dut (
    .AClk    (AClk),
    .AResetN (AResetN),
    .bus     (bus)
  );

  always #5 AClk = ~AClk;

  // RAM model: write at the edge, registered read data one cycle later.
  always @(posedge AClk) begin
    if (preload) mem[11'h005] <= 8'h5A;
    else if (bus.ARamWrEn) mem[bus.ARamAddr] <= bus.ARamMosi;
    if (bus.ARamRdEn) bus.ARamMiso <= mem[bus.ARamAddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.AReqAddr = '0;
    bus.AReqMosi = '0;
    bus.AReqWrEn = '0;
    bus.AReqRdEn = '0;
    bus.AReqLock = '0;
  endtask

  task automatic drive(input int i, input logic wr, input logic rd, input logic lk,
                       input logic [CAddrLen-1:0] a, input logic [CDataLen-1:0] d);
    bus.AReqAddr[i*CAddrLen +: CAddrLen] = a;
    bus.AReqMosi[i*CDataLen +: CDataLen] = d;
    bus.AReqWrEn[i] = wr;
    bus.AReqRdEn[i] = rd;
    bus.AReqLock[i] = lk;
  endtask

  task automatic tick();
    @(posedge AClk);
    #1;
  endtask

  initial begin
    clr();
    AResetN = 1'b0;
    preload = 1'b1;
    // A request held during reset must not be granted.
    drive(0, 1'b0, 1'b1, 1'b0, 11'h005, 8'h00);
    tick();
    tick();
    #1;
    chk("rst_ack",   32'(bus.AReqAck),     32'h0);
    chk("rst_rden",  32'(bus.ARamRdEn),    32'h0);
    chk("rst_addr",  32'(bus.ARamAddr),    32'h0);
    chk("rst_vld",   32'(bus.AReqMisoVld), 32'h0);
    chk("rst_miso",  32'(bus.AReqMiso),    32'h0);
    chk("rst_clken", 32'(bus.ARamClkEn),   32'h1);

    // req0 reads 0x005 right after reset.
    tick();
    preload = 1'b0;
    AResetN = 1'b1;
    #1;
    chk("rd0_ack",  32'(bus.AReqAck),  32'h1);
    chk("rd0_addr", 32'(bus.ARamAddr), 32'h005);
    chk("rd0_rden", 32'(bus.ARamRdEn), 32'h1);
    chk("rd0_wren", 32'(bus.ARamWrEn), 32'h0);
    tick();
    clr();
    #1;
    chk("rd0_vld",  32'(bus.AReqMisoVld), 32'h1);
    chk("rd0_miso", 32'(bus.AReqMiso),    32'h5A);
    chk("rd0_ack2", 32'(bus.AReqAck),     32'h0);

    // Fresh reset so rotation starts from FLast = 2.
    AResetN = 1'b0;
    tick();
    AResetN = 1'b1;
    for (int i = 0; i < 3; i++) rnd[i] = 0;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 3; i++)
        drive(i, 1'b1, 1'b0, 1'b0, 11'(32'h040 + 4*rnd[i] + i), 8'(32'h10*(i+1) + rnd[i]));
      #1;
      chk("rot_ack",  32'(bus.AReqAck),  32'(1 << (c % 3)));
      chk("rot_addr", 32'(bus.ARamAddr), 32'(32'h040 + 4*rnd[c % 3] + (c % 3)));
      rnd[c % 3]++;
      tick();
    end
    clr();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 3; i++)
        chk("rot_mem", 32'(mem[11'(32'h040 + 4*r + i)]), 32'(32'h10*(i+1) + r));

    // Read-after-write across consecutive grants.
    drive(1, 1'b1, 1'b0, 1'b0, 11'h010, 8'h33);
    #1;
    chk("raw_wr_ack", 32'(bus.AReqAck), 32'h2);
    tick();
    clr();
    drive(2, 1'b0, 1'b1, 1'b0, 11'h010, 8'h00);
    #1;
    chk("raw_rd_ack",  32'(bus.AReqAck),  32'h4);
    chk("raw_rd_rden", 32'(bus.ARamRdEn), 32'h1);
    tick();
    clr();
    #1;
    chk("raw_vld",  32'(bus.AReqMisoVld), 32'h4);
    chk("raw_miso", 32'(bus.AReqMiso),    32'h33);

    // Both enables set: write only.
    drive(0, 1'b1, 1'b1, 1'b0, 11'h020, 8'h77);
    #1;
    chk("both_ack",  32'(bus.AReqAck),  32'h1);
    chk("both_wren", 32'(bus.ARamWrEn), 32'h1);
    chk("both_rden", 32'(bus.ARamRdEn), 32'h0);
    chk("both_mosi", 32'(bus.ARamMosi), 32'h77);
    tick();
    clr();
    #1;
    chk("both_vld", 32'(bus.AReqMisoVld), 32'h0);
    chk("both_mem", 32'(mem[11'h020]),    32'h77);

    // Reset in the cycle after a read ack drops the return.
    drive(1, 1'b0, 1'b1, 1'b0, 11'h005, 8'h00);
    #1;
    chk("rstrd_ack", 32'(bus.AReqAck), 32'h2);
    tick();
    clr();
    AResetN = 1'b0;
    drive(2, 1'b0, 1'b1, 1'b0, 11'h010, 8'h00);
    #1;
    chk("rstrd_vld",  32'(bus.AReqMisoVld), 32'h0);
    chk("rstrd_miso", 32'(bus.AReqMiso),    32'h0);
    chk("rstrd_ack2", 32'(bus.AReqAck),     32'h0);
    chk("rstrd_rden", 32'(bus.ARamRdEn),    32'h0);
    chk("rstrd_addr", 32'(bus.ARamAddr),    32'h0);
    tick();
    AResetN = 1'b1;
    clr();
    drive(0, 1'b0, 1'b1, 1'b0, 11'h005, 8'h00);
    drive(1, 1'b0, 1'b1, 1'b0, 11'h010, 8'h00);
    drive(2, 1'b0, 1'b1, 1'b0, 11'h010, 8'h00);
    #1;
    chk("post_ack", 32'(bus.AReqAck),     32'h1);
    chk("post_vld", 32'(bus.AReqMisoVld), 32'h0);
    tick();
    clr();
    #1;
    chk("post_vld2", 32'(bus.AReqMisoVld), 32'h1);
    chk("post_miso", 32'(bus.AReqMiso),    32'h5A);

    // req2 holds a lock for four cycles while req0 waits.
    ack0_cyc = 0;
    n2       = 0;
    for (int c = 1; c <= 8; c++) begin
      clr();
      if (c <= 4) drive(2, 1'b1, 1'b0, 1'b1, 11'h030, 8'(c));
      if (c >= 2 && ack0_cyc == 0) drive(0, 1'b1, 1'b0, 1'b0, 11'h031, 8'hA0);
      #1;
      if (bus.AReqAck[0] && ack0_cyc == 0) ack0_cyc = c;
      if (bus.AReqAck[2]) n2++;
      tick();
    end
    clr();
    chk("lock_ack0_cycle", 32'(ack0_cyc), 32'(ExpAck0Cyc));
    chk("lock_req2_gnts",  32'(n2),       32'(ExpReq2Gnt));
    chk("lock_mem",        32'(mem[11'h031]), 32'hA0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
